// File: rtl/ms_clk_monitor_pkg.sv
// Shared types and constant helpers for the millisecond clock monitor.
// Range bounds are clamped so they cannot wrap below zero or above the counter width.
package ms_clk_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_e;

  function automatic int unsigned range_lo(int unsigned expected, int unsigned tol);
    return (expected > tol) ? (expected - tol) : 32'd0;
  endfunction

  function automatic int unsigned range_hi(int unsigned expected, int unsigned tol,
                                           int unsigned width);
    longint unsigned sum;
    longint unsigned max_v;
    sum   = 64'(expected) + 64'(tol);
    max_v = (64'd1 << width) - 64'd1;
    return (sum > max_v) ? 32'(max_v) : 32'(sum);
  endfunction

endpackage

// File: rtl/ms_clk_monitor_sync_edge_detect.sv
// Two-flop synchronizer with delay flop; exposes the combinational rising edge
// and a registered one-cycle tick. Reusable for any asynchronous level input.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_c,
  output logic tick
);

  logic sync1;
  logic sync2;
  logic dly;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dly   <= 1'b0;
      tick  <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      dly   <= sync2;
      tick  <= rise_c;
    end
  end

  assign rise_c = sync2 & ~dly;

endmodule

// File: rtl/ms_clk_monitor.sv
// Checks a slow clock sampled in the clk domain: emits a tick per rising edge,
// measures edge-to-edge period and reports lock / loss against the nominal period.
module ms_clk_monitor
  import ms_clk_monitor_pkg::*;
#(
  parameter int unsigned CNT_WIDTH       = 10,
  parameter int unsigned EXPECTED_PERIOD = 256,
  parameter int unsigned TOLERANCE       = 2,
  parameter int unsigned LOCK_COUNT      = 4,
  parameter int unsigned TIMEOUT         = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_ms,
  output logic                 tick,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_valid,
  output logic                 in_range,
  output logic                 locked,
  output logic                 lost
);

  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_WIDTH-1:0] RANGE_LO  = CNT_WIDTH'(range_lo(EXPECTED_PERIOD, TOLERANCE));
  localparam logic [CNT_WIDTH-1:0] RANGE_HI  = CNT_WIDTH'(range_hi(EXPECTED_PERIOD, TOLERANCE,
                                                                    CNT_WIDTH));
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(TIMEOUT);
  localparam logic [GOOD_W-1:0]    GOOD_LOCK = GOOD_W'(LOCK_COUNT);

  logic                 rise_c;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 cnt_in_range_c;
  logic [GOOD_W-1:0]    good_cnt;
  logic [GOOD_W-1:0]    good_nxt;
  state_e               state;
  state_e               state_nxt;
  logic [CNT_WIDTH-1:0] period_nxt;
  logic                 period_valid_nxt;
  logic                 in_range_nxt;

  sync_edge_detect u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (clk_ms),
    .rise_c   (rise_c),
    .tick     (tick)
  );

  // Period counter: restarts at 1 on each edge, saturates so it never wraps.
  always_comb begin
    cnt_nxt = cnt;
    if (rise_c) begin
      cnt_nxt = CNT_WIDTH'(1);
    end else if (cnt != CNT_MAX) begin
      cnt_nxt = cnt + CNT_WIDTH'(1);
    end
  end

  assign cnt_in_range_c = (cnt >= RANGE_LO) && (cnt <= RANGE_HI);

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt        = state;
    good_nxt         = good_cnt;
    period_nxt       = period;
    period_valid_nxt = 1'b0;
    in_range_nxt     = in_range;
    unique case (state)
      IDLE: begin
        if (rise_c) begin
          state_nxt = MEASURE;
        end
      end
      MEASURE, LOCKED: begin
        if (rise_c) begin
          period_nxt       = cnt;
          period_valid_nxt = 1'b1;
          in_range_nxt     = cnt_in_range_c;
          if (cnt_in_range_c) begin
            if (good_cnt != GOOD_LOCK) begin
              good_nxt = good_cnt + GOOD_W'(1);
            end
            if (good_nxt == GOOD_LOCK) begin
              state_nxt = LOCKED;
            end
          end else begin
            good_nxt  = '0;
            state_nxt = MEASURE;
          end
        end else if (cnt == CNT_MAX) begin
          good_nxt  = '0;
          state_nxt = LOST;
        end
      end
      LOST: begin
        if (rise_c) begin
          state_nxt = MEASURE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      good_cnt     <= '0;
      state        <= IDLE;
      period       <= '0;
      period_valid <= 1'b0;
      in_range     <= 1'b0;
      locked       <= 1'b0;
      lost         <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      good_cnt     <= good_nxt;
      state        <= state_nxt;
      period       <= period_nxt;
      period_valid <= period_valid_nxt;
      in_range     <= in_range_nxt;
      locked       <= (state_nxt == LOCKED);
      lost         <= (state_nxt == LOST);
    end
  end

endmodule

// File: tb/tb_ms_clk_monitor.sv
// Bench for ms_clk_monitor: directed and random clk_ms waveforms compared every
// cycle against an event-level model, plus literal expectations on key scenarios.
module tb_ms_clk_monitor;

  localparam int unsigned CW    = 10;
  localparam int          EXP   = 256;
  localparam int          TOL   = 2;
  localparam int          LOCKN = 4;
  localparam int          TMO   = 512;

  localparam int M_IDLE = 0;
  localparam int M_MEAS = 1;
  localparam int M_LOCK = 2;
  localparam int M_LOST = 3;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          clk_ms = 1'b0;
  logic          tick;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          in_range;
  logic          locked;
  logic          lost;

  logic ms_pe  = 1'b0;
  logic rst_pe = 1'b1;

  int checks = 0;
  int errors = 0;

  int pv_p[$];
  int pv_ir[$];
  int pv_lk[$];
  int lost_rises  = 0;
  int lost_delay  = 0;
  int lost_locked = 0;

  always #5 clk = ~clk;

  ms_clk_monitor #(
    .CNT_WIDTH       (CW),
    .EXPECTED_PERIOD (EXP),
    .TOLERANCE       (TOL),
    .LOCK_COUNT      (LOCKN),
    .TIMEOUT         (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_ms       (clk_ms),
    .tick         (tick),
    .period       (period),
    .period_valid (period_valid),
    .in_range     (in_range),
    .locked       (locked),
    .lost         (lost)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // What the DUT saw on each active edge.
  always @(posedge clk) begin
    ms_pe  <= clk_ms;
    rst_pe <= rst;
  end

  // Event-level reference: rises seen at posedge N appear after posedge N+2;
  // periods are differences of edge times.
  initial begin : model
    bit h[4];
    bit rise;
    int t, t_last, mode, good, e_period, cyc, last_tick;
    bit e_ir, e_pv, e_tick, lost_q;
    t = 0; t_last = 0; mode = M_IDLE; good = 0; e_period = 0;
    e_ir = 0; e_pv = 0; e_tick = 0; cyc = 0; last_tick = 0; lost_q = 0;
    h = '{default: 1'b0};
    forever begin
      @(negedge clk);
      cyc++;
      if (rst || rst_pe) begin
        h = '{default: 1'b0};
        t = 0; t_last = 0; mode = M_IDLE; good = 0;
        e_period = 0; e_ir = 0; e_pv = 0; e_tick = 0;
      end else begin
        h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = ms_pe;
        rise   = h[2] & ~h[3];
        t++;
        e_pv   = 0;
        e_tick = rise;
        if (rise) begin
          if (mode == M_MEAS || mode == M_LOCK) begin
            e_period = t - t_last;
            e_pv     = 1;
            e_ir     = (e_period >= EXP - TOL) && (e_period <= EXP + TOL);
            if (e_ir) begin
              good++;
              if (good >= LOCKN) mode = M_LOCK;
            end else begin
              good = 0;
              mode = M_MEAS;
            end
          end else begin
            mode = M_MEAS;
          end
          t_last = t;
        end else if ((mode == M_MEAS || mode == M_LOCK) && (t - t_last >= TMO)) begin
          mode = M_LOST;
          good = 0;
        end
      end
      chk("tick", 32'(tick), 32'(e_tick));
      chk("period_valid", 32'(period_valid), 32'(e_pv));
      chk("period", 32'(period), 32'(e_period));
      chk("in_range", 32'(in_range), 32'(e_ir));
      chk("locked", 32'(locked), 32'(mode == M_LOCK));
      chk("lost", 32'(lost), 32'(mode == M_LOST));

      if (period_valid) begin
        pv_p.push_back(int'(period));
        pv_ir.push_back(int'(in_range));
        pv_lk.push_back(int'(locked));
      end
      if (tick) last_tick = cyc;
      if (lost && !lost_q) begin
        lost_rises++;
        lost_delay  = cyc - last_tick;
        lost_locked = int'(locked);
      end
      lost_q = lost;
    end
  end

  task automatic gen(input int p, input int hi);
    for (int i = 0; i < p; i++) begin
      @(posedge clk);
      #1 clk_ms = (i < hi);
    end
  endtask

  task automatic gp(input int p);
    gen(p, p / 2);
  endtask

  task automatic chk_pv(input string name, input int idx, input int p, input int ir, input int lk);
    if (idx >= pv_p.size()) begin
      chk({name, "_present"}, 32'(pv_p.size()), 32'(idx + 1));
    end else begin
      chk({name, "_period"}, 32'(pv_p[idx]), 32'(p));
      chk({name, "_in_range"}, 32'(pv_ir[idx]), 32'(ir));
      chk({name, "_locked"}, 32'(pv_lk[idx]), 32'(lk));
    end
  endtask

  initial begin : stim
    int n0;
    int p;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    // Steady 256: first edge absorbed, lock on the 5th edge.
    n0 = pv_p.size();
    repeat (8) gp(256);
    chk("t1_pv_count", 32'(pv_p.size() - n0), 32'd7);
    for (int i = 0; i < 7; i++)
      chk_pv($sformatf("t1_%0d", i), n0 + i, 256, 1, (i >= 3) ? 1 : 0);

    // One stretched period drops lock; four good periods relock.
    n0 = pv_p.size();
    gp(260);
    repeat (5) gp(256);
    chk("t2_pv_count", 32'(pv_p.size() - n0), 32'd6);
    chk_pv("t2_pre", n0, 256, 1, 1);
    chk_pv("t2_260", n0 + 1, 260, 0, 0);
    for (int i = 2; i < 5; i++) chk_pv($sformatf("t2_%0d", i), n0 + i, 256, 1, 0);
    chk_pv("t2_relock", n0 + 5, 256, 1, 1);

    // Hold low until timeout.
    repeat (600) @(posedge clk);
    @(negedge clk);
    chk("t3_lost_rises", 32'(lost_rises), 32'd1);
    chk("t3_lost_delay", 32'(lost_delay), 32'd512);
    chk("t3_lost_locked", 32'(lost_locked), 32'd0);
    chk("t3_lost_now", 32'(lost), 32'd1);
    n0 = pv_p.size();
    gp(256);
    chk("t3_recover_no_pv", 32'(pv_p.size() - n0), 32'd0);
    chk("t3_lost_cleared", 32'(lost), 32'd0);

    // Edge exactly at the timeout count: edge wins.
    n0 = pv_p.size();
    gp(512);
    gp(256);
    chk_pv("t4_pre", n0, 256, 1, 0);
    chk_pv("t4_512", n0 + 1, 512, 0, 0);
    chk("t4_no_lost", 32'(lost_rises), 32'd1);

    // Tolerance boundaries.
    n0 = pv_p.size();
    gp(254); gp(258); gp(253); gp(259); gp(256);
    chk_pv("b_254", n0 + 1, 254, 1, 0);
    chk_pv("b_258", n0 + 2, 258, 1, 0);
    chk_pv("b_253", n0 + 3, 253, 0, 0);
    chk_pv("b_259", n0 + 4, 259, 0, 0);

    // Asynchronous reset mid-measurement.
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("r_tick", 32'(tick), 32'd0);
    chk("r_period", 32'(period), 32'd0);
    chk("r_period_valid", 32'(period_valid), 32'd0);
    chk("r_in_range", 32'(in_range), 32'd0);
    chk("r_locked", 32'(locked), 32'd0);
    chk("r_lost", 32'(lost), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n0 = pv_p.size();
    gp(256);
    chk("r_first_edge_no_pv", 32'(pv_p.size() - n0), 32'd0);
    gp(256);
    chk("r_second_edge_pv", 32'(pv_p.size() - n0), 32'd1);
    chk_pv("r_256", n0, 256, 1, 0);

    // Random periods and duty cycles, occasionally past the timeout.
    repeat (40) begin
      p = ($urandom_range(0, 9) == 0) ? int'($urandom_range(500, 520))
                                      : int'($urandom_range(250, 262));
      gen(p, int'($urandom_range(2, p - 2)));
    end

    // Reset released while clk_ms is high.
    @(posedge clk);
    #1 rst = 1'b1;
    clk_ms = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 clk_ms = 1'b0;
    repeat (5) @(posedge clk);
    repeat (15) begin
      p = int'($urandom_range(252, 260));
      gen(p, int'($urandom_range(2, p - 2)));
    end

    repeat (10) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ms_clk_monitor.md
# ms_clk_monitor

Receive-side checker for the millisecond clock produced by the team's clock divider. The block samples an externally generated slow clock `clk_ms` in the fast `clk` domain and emits a one-cycle `tick` per rising edge. It measures the period between edges in `clk` cycles and reports lock or loss against the expected period. It sits beside any consumer of `clk_ms` (watchdogs, SPI timeouts, LED blink logic) and gives them a clean, synchronous tick plus a health status.

## Interface
- `CNT_WIDTH`, 10 — width of the period counter and of `period`.
- `EXPECTED_PERIOD`, 256 — nominal `clk_ms` period in `clk` cycles (matches the divider's default width of 7).
- `TOLERANCE`, 2 — allowed ± deviation for a period to count as in range.
- `LOCK_COUNT`, 4 — number of consecutive in-range periods required to assert `locked`.
- `TIMEOUT`, 512 — number of cycles without an edge before `lost` asserts. Must be ≤ 2^CNT_WIDTH − 1.
- `clk` in 1 — system clock; everything is on its rising edge.
- `rst` in 1 — reset, asynchronous, active-high.
- `clk_ms` in 1 — slow clock under test, asynchronous to `clk`.
- `tick` out 1 — one-cycle pulse per synchronized rising edge of `clk_ms`.
- `period` out CNT_WIDTH — last measured period, held between updates.
- `period_valid` out 1 — one-cycle pulse when `period` updates.
- `in_range` out 1 — result for the last reported period: |period − EXPECTED_PERIOD| ≤ TOLERANCE. Held between updates.
- `locked` out 1 — the clock is healthy.
- `lost` out 1 — no edge seen for TIMEOUT cycles.

## Operation
**Front end**
- Two-flop synchronizer, then a delay flop. The edge condition is `sync2 & ~dly`.
- `tick` is registered: high for exactly 1 cycle per edge.

**Counter `cnt`**
- On an edge cycle, load `cnt` with 1.
- Otherwise increment, saturating at TIMEOUT.

**FSM states**
- IDLE (reset state).
  - On an edge, go to MEASURE.
  - No `period_valid` is produced.
- MEASURE:
  - On an edge, set `period` to `cnt` and pulse `period_valid`.
  - If the period is in range, increment `good_cnt`; otherwise set `good_cnt` to 0.
  - When `good_cnt` reaches LOCK_COUNT, go to LOCKED.
- LOCKED:
  - On an edge, report the period as in MEASURE.
  - An out-of-range period sends the FSM to MEASURE, sets `good_cnt` to 0, and drops `locked`.
- LOST:
  - Entered from MEASURE or LOCKED when `cnt` equals TIMEOUT and there is no edge in the same cycle.
  - On an edge, go to MEASURE, load `cnt` with 1, and do not report a period.

**Outputs by state**
- `locked` = (state == LOCKED).
- `lost` = (state == LOST).

**Arithmetic**
- The range check uses `RANGE_LO = EXPECTED_PERIOD − TOLERANCE` and `RANGE_HI = EXPECTED_PERIOD + TOLERANCE` as unsigned CNT_WIDTH constants.
- Neither constant may underflow or overflow.

## Timing
**Reset values**
- `tick`, `period_valid`, `in_range`, `locked`, `lost` = 0.
- `period` = 0, `cnt` = 0, `good_cnt` = 0.
- Synchronizer and delay flops = 0. State = IDLE.

**Latency**
- A `clk_ms` rise sampled at edge N gives `tick`, `period_valid`, `period` and `in_range` all valid in the same cycle after edge N+2.
- `locked` and `lost` update in that same cycle.

**Period measurement**
- A steady input period of P clk cycles reports `period` = P.
- `cnt` saturates at TIMEOUT, so it cannot wrap.

**Boundary conditions**
- An edge in the same cycle that `cnt` equals TIMEOUT: the edge wins. Report `period` = TIMEOUT with `in_range` = 0 and do not enter LOST.
- `clk_ms` high when reset releases may produce one `tick`. IDLE absorbs it, so no period is reported.
- Reset mid-operation returns every register to its reset value immediately (asynchronous reset).
- Input pulses shorter than 2 clk cycles may be missed. The spec does not require them to be caught.

## Structure
- Package `ms_clk_monitor_pkg` holds:
  - the 2-bit state encodings IDLE = 0, MEASURE = 1, LOCKED = 2, LOST = 3;
  - helper functions computing RANGE_LO and RANGE_HI from the parameters.
- Sub-module `sync_edge_detect`: 2-flop synchronizer plus delay flop and registered rising-edge pulse. It is reusable for other asynchronous inputs such as SPI CS and GPIO.
- Top level contains the counter, `good_cnt` (width $clog2(LOCK_COUNT+1)), the FSM and the output registers.

## Test plan
1. Steady `clk_ms` with period 256 from the default divider:
   - first edge gives `tick` only;
   - the next 4 edges give `period` = 256 and `in_range` = 1;
   - `locked` rises in the cycle of the 5th edge's `tick`.
2. While locked, stretch one period to 260:
   - `period` = 260, `in_range` = 0;
   - `locked` falls in that cycle;
   - relock after 4 further in-range periods.
3. Hold `clk_ms` low after lock:
   - `lost` = 1 exactly 512 cycles after the last edge's `tick`, and `locked` = 0;
   - the next edge clears `lost` with no `period_valid`.
4. Make an edge coincide with `cnt` = 512:
   - `period_valid` = 1, `period` = 512, `in_range` = 0;
   - `lost` stays 0.
5. Assert `rst` mid-measurement:
   - all outputs are 0 immediately (asynchronous);
   - after release, the first edge gives no `period_valid`.
6. Periods of 254 and 258 (boundary):
   - both give `in_range` = 1.
   - Periods of 253 and 259 give `in_range` = 0.
